// File: rtl/matmul_apb_master.sv
// matmul_apb_master: single-outstanding APB4 requester for the matrix-multiplier
// register port. One command in, one SETUP/ACCESS transfer out, one response back.
// Optional feature macro: MATMUL_APB_BUSY_GATE_EN. When it is defined, write
// commands are held off while busy_i is high. Reads are always accepted so that
// software can keep polling status.
//
// state  | meaning
// IDLE   | bus idle, ready to accept a command
// SETUP  | psel high, penable low (one cycle)
// ACCESS | psel and penable high, waiting for pready or timeout
// RESP   | response presented until rsp_ready_i
module matmul_apb_master #(
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int STRB_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [STRB_WIDTH-1:0] cmd_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_slverr_o,
  output logic                  rsp_timeout_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [STRB_WIDTH-1:0] pstrb_o,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic                  busy_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Counter is sized for the largest legal timeout (65535).
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_cnt;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [BUS_WIDTH-1:0]  r_pwdata;
  logic [STRB_WIDTH-1:0] r_pstrb;
  logic [BUS_WIDTH-1:0]  r_rdata;
  logic                  r_slverr;
  logic                  r_timeout;

  logic w_gate;
  logic w_accept;
  logic w_done;
  logic w_expire;

`ifdef MATMUL_APB_BUSY_GATE_EN
  assign w_gate = ~(cmd_write_i & busy_i);
`else
  // busy_i only matters when the gate is built in.
  logic w_unused_busy;
  assign w_unused_busy = busy_i;
  assign w_gate        = 1'b1;
`endif

  assign w_accept = (r_state == IDLE) & w_gate & cmd_valid_i;
  assign w_done   = (r_state == ACCESS) & pready_i;
  assign w_expire = (r_state == ACCESS) & ~pready_i & (r_cnt == LP_CNT_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (w_done || w_expire) w_state_nxt = RESP;
      RESP:    if (rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control outputs decoded from state; cmd_ready is forced low during reset.
  always_comb begin
    cmd_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (r_state)
      IDLE:    cmd_ready_o = w_gate & rst_ni;
      SETUP:   psel_o      = 1'b1;
      ACCESS:  begin psel_o = 1'b1; penable_o = 1'b1; end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Wait-state counter: counts pready-low ACCESS cycles, cleared when the response is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             r_cnt <= '0;
    else if ((r_state == RESP) && rsp_ready_i) r_cnt <= '0;
    else if ((r_state == ACCESS) && !pready_i && !w_expire) r_cnt <= r_cnt + 16'd1;
  end

  // Command latch; reads carry zero data and strobes onto the bus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write_i;
      r_paddr  <= cmd_addr_i;
      r_pwdata <= cmd_write_i ? cmd_wdata_i : '0;
      r_pstrb  <= cmd_write_i ? cmd_strb_i  : '0;
    end
  end

  // Response capture at the end of ACCESS, either completion or timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_done) begin
      r_rdata   <= r_pwrite ? '0 : prdata_i;
      r_slverr  <= pslverr_i;
      r_timeout <= 1'b0;
    end else if (w_expire) begin
      r_rdata   <= '0;
      r_slverr  <= 1'b1;
      r_timeout <= 1'b1;
    end
  end

  assign pwrite_o      = r_pwrite;
  assign paddr_o       = r_paddr;
  assign pwdata_o      = r_pwdata;
  assign pstrb_o       = r_pstrb;
  assign rsp_rdata_o   = r_rdata;
  assign rsp_slverr_o  = r_slverr;
  assign rsp_timeout_o = r_timeout;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Bench for matmul_apb_master: drives commands, models an APB slave with
// programmable wait states and errors, and scores responses from a queue.
module tb_matmul_apb_master;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
  logic [15:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic [3:0]  cmd_strb_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_slverr_o, rsp_timeout_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [15:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0, pslverr_i = 1'b0, busy_i = 1'b0;

  typedef struct {logic [31:0] rdata; logic slverr; logic timeout;} rsp_t;
  rsp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  matmul_apb_master #(.BUS_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_slverr_o(rsp_slverr_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .busy_i(busy_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One complete transfer. Called on a negedge with the DUT idle.
  // waits: pready-low ACCESS cycles; never: pready never comes; hold: RESP cycles with rsp_ready low.
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int waits, input bit err,
                         input bit never, input int hold);
    rsp_t e;
    int acc;
    logic [31:0] rd;
    rd = $urandom;
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wd; cmd_strb_i = st;
    #1 chk("cmd_ready_idle", cmd_ready_o, 1);
    e.timeout = never;
    e.slverr  = never ? 1'b1 : err;
    e.rdata   = (never || wr) ? 32'h0 : rd;
    sb_q.push_back(e);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk("setup_psel", psel_o, 1);
    chk("setup_penable", penable_o, 0);
    chk("setup_cmd_ready", cmd_ready_o, 0);
    chk("setup_paddr", paddr_o, addr);
    chk("setup_pwrite", pwrite_o, wr);
    chk("setup_pwdata", pwdata_o, wr ? wd : 32'h0);
    chk("setup_pstrb", pstrb_o, wr ? st : 4'h0);
    // Extra command presented while busy must be ignored.
    cmd_valid_i = 1'b1; cmd_addr_i = 16'hFFFF; cmd_wdata_i = 32'hA5A5A5A5;
    @(negedge clk_i);
    acc = 0;
    while (psel_o && penable_o && acc < 60) begin
      acc++;
      if (acc == 1) begin
        chk("access_paddr", paddr_o, addr);
        chk("access_pstrb", pstrb_o, wr ? st : 4'h0);
        chk("access_cmd_ready", cmd_ready_o, 0);
      end
      pready_i  = !never && (acc > waits);
      prdata_i  = pready_i ? rd : $urandom;
      pslverr_i = pready_i ? err : 1'b1;
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom;
    chk("access_cycles", acc, never ? TO : waits + 1);
    for (int i = 0; i <= hold; i++) begin
      chk("resp_valid", rsp_valid_o, 1);
      chk("resp_psel", psel_o, 0);
      chk("resp_cmd_ready", cmd_ready_o, 0);
      if (i == hold) begin
        rsp_ready_i = 1'b1;
        if (sb_q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_slverr", rsp_slverr_o, e.slverr);
          chk("rsp_timeout", rsp_timeout_o, e.timeout);
        end
      end
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b0;
    chk("post_rsp_valid", rsp_valid_o, 0);
    chk("post_psel", psel_o, 0);
  endtask

  initial begin
    #2;
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_psel", psel_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_paddr", paddr_o, 0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_txn(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0, 0);
    run_txn(1'b0, 16'h0004, 32'hCAFEF00D, 4'hF, 3, 1'b0, 1'b0, 0);
    run_txn(1'b1, 16'h0020, 32'h01020304, 4'h3, 0, 1'b1, 1'b0, 5);
    run_txn(1'b0, 16'h0008, 32'h0, 4'h0, 0, 1'b0, 1'b1, 0);
    run_txn(1'b0, 16'h000C, 32'h0, 4'h0, 1, 1'b1, 1'b0, 1);

    // Reset during ACCESS: bus and response drop at once, nothing is returned.
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h0030;
    @(negedge clk_i); cmd_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_penable", penable_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_psel", psel_o, 0);
    chk("arst_penable", penable_o, 0);
    chk("arst_rsp_valid", rsp_valid_o, 0);
    chk("arst_cmd_ready", cmd_ready_o, 0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_rsp_valid", rsp_valid_o, 0);
    run_txn(1'b0, 16'h0004, 32'h0, 4'h0, 2, 1'b0, 1'b0, 0);

`ifdef MATMUL_APB_BUSY_GATE_EN
    busy_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 16'h0040;
    for (int i = 0; i < 10; i++) begin
      #1 chk("busy_wr_ready", cmd_ready_o, 0);
      @(negedge clk_i);
      chk("busy_wr_psel", psel_o, 0);
    end
    run_txn(1'b0, 16'h0044, 32'h0, 4'h0, 0, 1'b0, 1'b0, 0);
    busy_i = 1'b0;
    run_txn(1'b1, 16'h0040, 32'h55AA55AA, 4'hC, 0, 1'b0, 1'b0, 0);
`else
    busy_i = 1'b1;
    run_txn(1'b1, 16'h0040, 32'h55AA55AA, 4'hC, 0, 1'b0, 1'b0, 0);
    busy_i = 1'b0;
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_apb_master.md
Name: matmul_apb_master

Overview:
- Upstream APB4 requester that drives the matrix-multiplier APB slave port.
- Accepts one register command at a time on a valid/ready command channel and runs the APB SETUP→ACCESS sequence.
- Waits for pready and returns read data and error status on a valid/ready response channel.
- Used by the test harness and the SoC-side command sequencer as the only driver of the multiplier's APB port.

Parameters:
- BUS_WIDTH, 32, width of pwdata/prdata and command/response data.
- ADDR_WIDTH, 16, width of paddr and command address.
- STRB_WIDTH, 4, width of pstrb / command byte strobes (BUS_WIDTH/8).
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles with pready low before abort; legal range 2..65535.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  command accepted when valid&ready.
- cmd_write_i  input  1  1=write, 0=read.
- cmd_addr_i  input  ADDR_WIDTH  target register address.
- cmd_wdata_i  input  BUS_WIDTH  write data.
- cmd_strb_i  input  STRB_WIDTH  write byte strobes.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  response consumed when valid&ready.
- rsp_rdata_o  output  BUS_WIDTH  captured prdata (0 for writes and on timeout).
- rsp_slverr_o  output  1  pslverr captured, or forced 1 on timeout.
- rsp_timeout_o  output  1  transfer aborted by timeout.
- psel_o  output  1  APB select.
- penable_o  output  1  APB enable.
- pwrite_o  output  1  APB direction.
- paddr_o  output  ADDR_WIDTH  APB address.
- pwdata_o  output  BUS_WIDTH  APB write data.
- pstrb_o  output  STRB_WIDTH  APB strobes.
- prdata_i  input  BUS_WIDTH  APB read data.
- pready_i  input  1  APB ready.
- pslverr_i  input  1  APB slave error.
- busy_i  input  1  multiplier busy flag; used only with the optional feature.

Behaviour:
- Reset (async, rst_ni=0): state IDLE; all outputs 0 (cmd_ready_o=0 while rst_ni low); timeout counter 0. Reset mid-transfer drops psel/penable immediately; no response is generated for the lost command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: cmd_ready_o=1. On cmd_valid_i, latch write/addr/wdata/strb and go to SETUP.
  - SETUP (1 cycle): psel=1, penable=0, paddr/pwrite/pwdata/pstrb driven from the latched command; then go to ACCESS.
  - ACCESS: psel=1, penable=1, bus signals held stable. If pready_i=1, capture prdata_i (reads only; writes return 0) and pslverr_i, then go to RESP. If pready_i=0, increment the counter.
  - ACCESS timeout: if the counter reaches TIMEOUT_CYCLES-1 with pready_i still 0, go to RESP with rsp_slverr=1, rsp_timeout=1, rdata=0.
  - RESP: psel=penable=0, rsp_valid_o=1. Response fields held stable until rsp_ready_i=1; then go to IDLE and clear the counter.
- cmd_ready_o is 0 in every state except IDLE. There are no back-to-back APB transfers; at least 1 idle bus cycle separates transfers.
- Latency: command accepted at cycle N → SETUP N+1 → ACCESS N+2 → rsp_valid_o at N+3 when pready=1 in the first ACCESS cycle. Each pready-low cycle adds 1.
- Reads: pstrb_o=0 and pwdata_o=0 (APB4 rule), regardless of cmd_strb_i.
- pslverr_i is sampled only in the ACCESS cycle where pready_i=1; it is ignored otherwise.
- rsp_ready_i already high on the first RESP cycle: one RESP cycle, then IDLE.
- cmd_valid_i in non-IDLE states is ignored (not accepted).

Optional Feature:
- Macro: MATMUL_APB_BUSY_GATE_EN.
- Defined: in IDLE, cmd_ready_o = ~busy_i for writes. A write command waiting while busy_i=1 is not accepted until busy_i=0. Reads are accepted regardless of busy_i (status polling).
- Undefined: busy_i is ignored; cmd_ready_o=1 in IDLE for all commands.

Test Plan:
- Write addr 0x0010, data 0xDEADBEEF, strb 0xF, pready tied 1 → SETUP then ACCESS with matching bus values; rsp_valid at accept+3; slverr=0, rdata=0.
- Read addr 0x0004, slave returns 0x12345678 after 3 wait cycles → penable high 4 cycles, pstrb=0; rsp_rdata=0x12345678 at accept+6.
- Write with pslverr=1 alongside pready=1 → rsp_slverr=1, rsp_timeout=0; rsp held 5 cycles with rsp_ready=0, then released; cmd_ready low throughout.
- pready never asserted, TIMEOUT_CYCLES=8 → psel drops after 8 ACCESS cycles; rsp_slverr=1, rsp_timeout=1, rdata=0.
- Assert rst_ni=0 during ACCESS → psel, penable, rsp_valid go 0 asynchronously; after release, a new read completes normally.
- With MATMUL_APB_BUSY_GATE_EN and busy_i=1 → write not accepted for 10 cycles; read accepted immediately; busy_i=0 → write accepted next cycle.
